// File: rtl/dh_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : dh_pkg                                                    |
// | Brief  : Shared types and helpers for the Diffie-Hellman modular   |
// |          exponentiator (state encoding, latency function).         |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
package dh_pkg;

  localparam int DH_WIDTH = 32;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CAPT = 3'd1,
    S_RED  = 3'd2,
    S_SQR  = 3'd3,
    S_MUL  = 3'd4,
    S_FIN  = 3'd5
  } dh_state_e;

  // Cycles from accepted start to done: capture + (1 reduce + 2 per bit) multiplies + finish
  function automatic int dh_exp_lat(input int width);
    return 2 + (2 * width + 1) * (width + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dh_mod_mul.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : dh_mod_mul                                                |
// | Brief  : Interleaved (Blakley) modular multiplier, prod = a*b mod p|
// |          One issue cycle plus WIDTH iteration cycles per product.  |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module dh_mod_mul #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] p_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] prod_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int XW = WIDTH + 2;

  logic             busy_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [XW-1:0]    b_q;
  logic [XW-1:0]    p_q;
  logic [XW-1:0]    acc_q;

  logic [XW-1:0]    w_dbl;
  logic [XW-1:0]    w_dbl_red;
  logic [XW-1:0]    w_add;
  logic [XW-1:0]    w_add_red;

  // One Blakley step: double, reduce, conditionally add b, reduce (both reductions single-subtract)
  always_comb begin
    w_dbl     = acc_q << 1;
    w_dbl_red = (w_dbl >= p_q) ? (w_dbl - p_q) : w_dbl;
    w_add     = a_q[WIDTH-1] ? (w_dbl_red + b_q) : w_dbl_red;
    w_add_red = (w_add >= p_q) ? (w_add - p_q) : w_add;
  end

  // Operand load on issue, then one multiplier bit per cycle MSB-first
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      p_q    <= '0;
      acc_q  <= '0;
    end else if (start_i && !busy_q) begin
      busy_q <= 1'b1;
      cnt_q  <= CW'(WIDTH);
      a_q    <= a_i;
      b_q    <= {2'b00, b_i};
      p_q    <= {2'b00, p_i};
      acc_q  <= '0;
    end else if (busy_q) begin
      acc_q <= w_add_red;
      a_q   <= a_q << 1;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_q <= 1'b0;
      end
    end
  end

  // Final product is presented combinationally during the last iteration cycle
  assign busy_o = busy_q;
  assign done_o = busy_q && (cnt_q == CW'(1));
  assign prod_o = w_add_red[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/dh_mod_exp.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : dh_mod_exp                                                |
// | Brief  : Constant-time modular exponentiator, base^exp mod modulus |
// |          (left-to-right square and always-multiply).               |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module dh_mod_exp
  import dh_pkg::*;
#(
  parameter int WIDTH = DH_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  dh_state_e        state_q, state_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] mod_q, mod_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] br_q, br_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;

  logic             mul_start;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic             mul_busy;
  logic             mul_done;
  logic [WIDTH-1:0] mul_prod;

  dh_mod_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .CLK     (CLK),
    .RST     (RST),
    .start_i (mul_start),
    .a_i     (mul_a),
    .b_i     (mul_b),
    .p_i     (mod_q),
    .busy_o  (mul_busy),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );

  // State and datapath registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      exp_q    <= '0;
      mod_q    <= '0;
      acc_q    <= '0;
      br_q     <= '0;
      bit_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      exp_q    <= exp_d;
      mod_q    <= mod_d;
      acc_q    <= acc_d;
      br_q     <= br_d;
      bit_q    <= bit_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  // Sequencing: every op state issues one multiply and advances on its completion
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    exp_d     = exp_q;
    mod_d     = mod_q;
    acc_d     = acc_q;
    br_d      = br_q;
    bit_d     = bit_q;
    result_d  = result_q;
    err_d     = err_q;
    mul_start = 1'b0;
    mul_a     = acc_q;
    mul_b     = acc_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = base;
          exp_d   = exponent;
          mod_d   = modulus;
          state_d = S_CAPT;
        end
      end

      S_CAPT: begin
        if (mod_q == '0) begin
          err_d    = 1'b1;
          result_d = '0;
          state_d  = S_FIN;
        end else begin
          err_d   = 1'b0;
          acc_d   = (mod_q == WIDTH'(1)) ? '0 : WIDTH'(1);
          bit_d   = BW'(WIDTH - 1);
          state_d = S_RED;
        end
      end

      // base*1 mod P brings an out-of-range base below the modulus
      S_RED: begin
        mul_a     = base_q;
        mul_b     = WIDTH'(1);
        mul_start = !mul_busy;
        if (mul_done) begin
          br_d    = mul_prod;
          state_d = S_SQR;
        end
      end

      S_SQR: begin
        mul_start = !mul_busy;
        if (mul_done) begin
          acc_d   = mul_prod;
          state_d = S_MUL;
        end
      end

      // Multiply always runs; only the write-back depends on the exponent bit
      S_MUL: begin
        mul_b     = br_q;
        mul_start = !mul_busy;
        if (mul_done) begin
          if (exp_q[bit_q]) begin
            acc_d = mul_prod;
          end
          if (bit_q == '0) begin
            result_d = exp_q[bit_q] ? mul_prod : acc_q;
            state_d  = S_FIN;
          end else begin
            bit_d   = bit_q - BW'(1);
            state_d = S_SQR;
          end
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy   = (state_q != S_IDLE) && (state_q != S_FIN);
  assign done   = (state_q == S_FIN);
  assign err    = err_q;
  assign result = result_q;

endmodule
`default_nettype wire
